cla_pipe_adder: RTL and testbench
=================================

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; legal values are multiples of GROUP, 8..64.
REQ-002 SHALL have parameter GROUP, default 4, meaning bits per lookahead group.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port sub  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry out of the MSB; for subtraction it is the not-borrow bit.
REQ-014 SHALL have port ovf  output  1  signed overflow (present only under CLA_PIPE_OVF_EN).

Function
REQ-015 SHALL transfer an input beat when in_valid and in_ready are both 1 in the same cycle, and an output beat when out_valid and out_ready are both 1.
REQ-016 SHALL form b_eff = b XOR {WIDTH{sub}} and cin = sub, so that subtraction is A + ~B + 1.
REQ-017 Stage 1 SHALL register, per bit, p = a^b_eff and g = a&b_eff, plus per-group P/G and cin, with a valid bit s1_v.
REQ-018 Stage 2 SHALL compute group carries by lookahead, then in-group carries, then sum[i] = p[i] ^ c[i], and register sum, cout, and ovf with a valid bit s2_v.
REQ-019 Latency SHALL be exactly 2 cycles from input acceptance to out_valid when out_ready stays 1; throughput SHALL be 1 beat per cycle.
REQ-020 Stage 2 SHALL advance when !s2_v or out_ready; stage 1 SHALL advance when !s1_v or stage 2 advances; in_ready SHALL equal the stage 1 advance condition (combinational ready chain, no skid buffer).
REQ-021 While out_valid=1 and out_ready=0, sum, cout, and ovf SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-022 A bubble (s1_v=0) SHALL be allowed to be overwritten while the downstream stage is stalled.
REQ-023 Beats SHALL emerge in acceptance order; with 2 stages, at most 2 beats SHALL be in flight.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL be carry out of bit WIDTH-1.
REQ-025 ovf SHALL equal c[WIDTH-1] XOR cout.

Reset
REQ-026 While rst=1 at a clock edge, s1_v, s2_v, out_valid, sum, cout, and ovf SHALL all be 0.
REQ-027 in_ready SHALL be 1 during and after reset.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight beats, with no output beat in the cycle after reset.

Configuration
REQ-029 With macro CLA_PIPE_OVF_EN defined, the ovf port and its stage 2 register SHALL exist as in REQ-025.
REQ-030 Without CLA_PIPE_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package cla_pkg SHALL hold the GROUP default constant and the stage 1 payload struct typedef {p, g, gp, gg, cin}.
REQ-032 Sub-module cla_group SHALL be used, computing the GROUP-bit group P/G and the in-group carries from p, g, and carry-in; it is instantiated WIDTH/GROUP times.

Verification
REQ-033 Scenario: a=0x0000_0001, b=0xFFFF_FFFF, sub=0 -> sum=0, cout=1, ovf=0, 2 cycles after acceptance.
REQ-034 Scenario: a=0x7FFF_FFFF, b=1, sub=0 -> sum=0x8000_0000, cout=0, ovf=1.
REQ-035 Scenario: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0; and a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-036 Scenario: 4 back-to-back beats, then out_ready=0 for 3 cycles -> in_ready drops after 2 more beats are accepted, outputs hold, and all 4 results emerge in order after release.
REQ-037 Scenario: rst pulsed while 2 beats are in flight -> out_valid=0 in the following cycle, no stale beat emerges, in_ready=1.
REQ-038 Scenario: random 10k beats with random in_valid/out_ready, for WIDTH=32 and WIDTH=8 -> every result matches a reference model of a+b or a-b, including cout and ovf.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and the stage 1 payload layout for the pipelined CLA adder.
// The payload is sized for the widest legal adder; narrower builds zero the
// lanes above WIDTH (or above WIDTH/GROUP for the group fields).
package cla_pkg;

  localparam int CLA_GROUP_DEF = 4;   // default bits per lookahead group
  localparam int CLA_MAX_W     = 64;  // widest supported operand
  localparam int CLA_MAX_NG    = 64;  // most groups possible (GROUP = 1)

  // Stage 1 register contents: per-bit propagate/generate, per-group P/G,
  // and the carry-in (1 for subtraction).
  typedef struct packed {
    logic [CLA_MAX_W-1:0]  p;
    logic [CLA_MAX_W-1:0]  g;
    logic [CLA_MAX_NG-1:0] gp;
    logic [CLA_MAX_NG-1:0] gg;
    logic                  cin;
  } s1_pay_t;

endpackage

// File: rtl/cla_group.sv
// One lookahead group: group propagate/generate and the carry into each bit.
// Ports: p, g (per-bit propagate/generate), ci (group carry-in),
//        gp, gg (group propagate/generate), c (carry into each bit, c[0] = ci).
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             ci,
  output logic             gp,
  output logic             gg,
  output logic [GROUP-1:0] c
);

  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int j = 1; j < GROUP; j++) begin
      c[j] = g[j-1] | (p[j-1] & c[j-1]);
    end
  end

  always_comb begin
    gp = 1'b1;
    gg = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      gp = gp & p[j];
      gg = g[j] | (p[j] & gg);
    end
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/a/b/sub (operand beat),
//        out_valid/out_ready/sum/cout (result beat), ovf (signed overflow,
//        present only when CLA_PIPE_OVF_EN is defined). Latency 2, 1 beat/cycle.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = CLA_GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NG = WIDTH / GROUP;

  // ---------------- ready chain ----------------
  logic s1_v, s2_v;
  logic s1_adv, s2_adv;

  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = !s1_v || s2_adv;
  // Held high through reset: anything offered then is simply dropped.
  assign in_ready  = rst || s1_adv;
  assign out_valid = s2_v;

  // ---------------- stage 1: per-bit and per-group P/G ----------------
  logic [WIDTH-1:0] b_eff, p1, g1;
  logic [NG-1:0]    gp1, gg1;
  s1_pay_t          pay_d, s1_q;

  assign b_eff = b ^ {WIDTH{sub}};
  assign p1    = a ^ b_eff;
  assign g1    = a & b_eff;

  always_comb begin
    gp1 = '1;
    gg1 = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        gp1[k] = gp1[k] & p1[k*GROUP+j];
        gg1[k] = g1[k*GROUP+j] | (p1[k*GROUP+j] & gg1[k]);
      end
    end
  end

  always_comb begin
    pay_d              = '0;
    pay_d.p[WIDTH-1:0] = p1;
    pay_d.g[WIDTH-1:0] = g1;
    pay_d.gp[NG-1:0]   = gp1;
    pay_d.gg[NG-1:0]   = gg1;
    pay_d.cin          = sub;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (s1_adv) begin
      // A bubble in stage 1 is overwritten even while stage 2 is stalled.
      s1_v <= in_valid;
      s1_q <= pay_d;
    end
  end

  // ---------------- stage 2: carries and sum ----------------
  logic [WIDTH-1:0] p2, g2, c2, sum_d;
  logic [NG-1:0]    gp2, gg2, grp_gp, grp_gg;
  logic [NG:0]      gc;
  logic             cout_d;

  assign p2  = s1_q.p[WIDTH-1:0];
  assign g2  = s1_q.g[WIDTH-1:0];
  assign gp2 = s1_q.gp[NG-1:0];
  assign gg2 = s1_q.gg[NG-1:0];

  // Group-level carry lookahead; synthesis flattens this recurrence into
  // the two-level form c[k+1] = G[k] | P[k]G[k-1] | ... | P[k]..P[0]cin.
  always_comb begin
    gc    = '0;
    gc[0] = s1_q.cin;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg2[k] | (gp2[k] & gc[k]);
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .p  (p2[k*GROUP +: GROUP]),
      .g  (g2[k*GROUP +: GROUP]),
      .ci (gc[k]),
      .gp (grp_gp[k]),
      .gg (grp_gg[k]),
      .c  (c2[k*GROUP +: GROUP])
    );
  end

  assign sum_d  = p2 ^ c2;
  assign cout_d = gc[NG];

  // Group P/G are taken from stage 1 registers, so the instances' own group
  // outputs and the zeroed payload lanes above WIDTH are deliberately idle.
  logic unused_bits;
  assign unused_bits = ^{s1_q, grp_gp, grp_gg};

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef CLA_PIPE_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (s2_adv) begin
      s2_v <= s1_v;
      // Result registers only move on a real beat, so they hold under stall.
      if (s1_v) begin
        sum  <= sum_d;
        cout <= cout_d;
`ifdef CLA_PIPE_OVF_EN
        ovf  <= c2[WIDTH-1] ^ cout_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
`timescale 1ns/1ps
module tb_cla_pipe_adder;

  logic        clk, rst, in_valid, out_ready, sub;
  logic [31:0] a32, b32, sum32;
  logic [7:0]  a8, b8, sum8;
  logic        rdy32, vld32, cout32, rdy8, vld8, cout8;
`ifdef CLA_PIPE_OVF_EN
  logic        ovf32, ovf8;
`endif

  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .a(a32), .b(b32), .sub(sub), .out_valid(vld32), .out_ready(out_ready),
    .sum(sum32),
`ifdef CLA_PIPE_OVF_EN
    .ovf(ovf32),
`endif
    .cout(cout32)
  );

  cla_pipe_adder #(.WIDTH(8), .GROUP(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .a(a8), .b(b8), .sub(sub), .out_valid(vld8), .out_ready(out_ready),
    .sum(sum8),
`ifdef CLA_PIPE_OVF_EN
    .ovf(ovf8),
`endif
    .cout(cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input int w);
    logic [31:0] m, be;
    logic [32:0] full;
    logic        sa, sb, sr;
    res_t        r;
    m      = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    be     = (s ? ~b : b) & m;
    full   = {1'b0, a & m} + {1'b0, be} + {32'b0, s};
    r.sum  = full[31:0] & m;
    r.cout = full[w];
    sa     = a[w-1];
    sb     = b[w-1];
    sr     = r.sum[w-1];
    r.ovf  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return r;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
    a32 = a;
    b32 = b;
    a8  = a[7:0];
    b8  = b[7:0];
    sub = s;
  endtask

  // ---------------- scoreboard (both widths) ----------------
  res_t q32[$], q8[$];
  bit   sb_en = 1'b0;

  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      q32.delete();
      q8.delete();
    end else if (sb_en) begin
      if (vld32 && out_ready) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb32_stale: unexpected beat sum %0h, none outstanding", sum32);
        end else begin
          e = q32.pop_front();
          chk("sb32_sum", sum32, e.sum);
          chk("sb32_cout", cout32, e.cout);
`ifdef CLA_PIPE_OVF_EN
          chk("sb32_ovf", ovf32, e.ovf);
`endif
        end
      end
      if (vld8 && out_ready) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb8_stale: unexpected beat sum %0h, none outstanding", sum8);
        end else begin
          e = q8.pop_front();
          chk("sb8_sum", sum8, e.sum);
          chk("sb8_cout", cout8, e.cout);
`ifdef CLA_PIPE_OVF_EN
          chk("sb8_ovf", ovf8, e.ovf);
`endif
        end
      end
      if (in_valid && rdy32) q32.push_back(model(a32, b32, sub, 32));
      if (in_valid && rdy8)  q8.push_back(model({24'b0, a8}, {24'b0, b8}, sub, 8));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 11))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t        tbl[11];
  logic [31:0] st_a[4];
  logic [31:0] st_b[4];
  res_t        exp0;
  int          sent, cyc;

  initial begin
    tbl[0]  = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tbl[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
    tbl[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[8]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    tbl[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[10] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

    st_a = '{32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFF0, 32'h4000_0000};
    st_b = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0010, 32'h4000_0000};

    // ---------------- reset state ----------------
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", vld32, 1'b0);
    chk("rst_sum", sum32, 32'h0);
    chk("rst_cout", cout32, 1'b0);
    chk("rst_in_ready", rdy32, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", rdy32, 1'b1);

    // ---------------- directed table, exact latency ----------------
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      drive(tbl[i].a, tbl[i].b, tbl[i].s);
      @(negedge clk);
      chk("tbl_in_ready", rdy32, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("tbl_lat1_valid", vld32, 1'b0);
      @(posedge clk); #1;
      chk("tbl_lat2_valid", vld32, 1'b1);
      chk("tbl_sum", sum32, tbl[i].sum);
      chk("tbl_cout", cout32, tbl[i].cout);
`ifdef CLA_PIPE_OVF_EN
      chk("tbl_ovf", ovf32, tbl[i].ovf);
`endif
      @(posedge clk); #1;
    end
    sb_en = 1'b1;

    // ---------------- stall: two accepted, then ready drops ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(st_a[0], st_b[0], 1'b0);
    @(negedge clk); chk("stall_acc0", rdy32, 1'b1);
    @(posedge clk); #1; drive(st_a[1], st_b[1], 1'b0);
    @(negedge clk); chk("stall_acc1", rdy32, 1'b1);
    @(posedge clk); #1; drive(st_a[2], st_b[2], 1'b0);
    @(negedge clk); chk("stall_rdy_drop", rdy32, 1'b0);
    exp0 = model(st_a[0], st_b[0], 1'b0, 32);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_hold_valid", vld32, 1'b1);
      chk("stall_hold_sum", sum32, exp0.sum);
      chk("stall_hold_cout", cout32, exp0.cout);
      chk("stall_hold_rdy", rdy32, 1'b0);
    end
    out_ready = 1'b1;
    sent = 2; cyc = 0;
    while (sent < 4 && cyc < 20) begin
      in_valid = 1'b1;
      drive(st_a[sent], st_b[sent], 1'b0);
      @(negedge clk);
      if (rdy32) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stall_all_sent", sent, 4);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_drained32", q32.size(), 0);
    chk("stall_drained8", q8.size(), 0);

    // ---------------- reset with two beats in flight ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(32'hDEAD_0001, 32'h0000_0100, 1'b0);
    @(posedge clk); #1;
    drive(32'hDEAD_0002, 32'h0000_0200, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_valid", vld32, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", vld32, 1'b0);
    chk("midrst_out_valid8", vld8, 1'b0);
    chk("midrst_in_ready", rdy32, 1'b1);
    chk("midrst_sum", sum32, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", vld32, 1'b0);
    end
    chk("midrst_in_ready_after", rdy32, 1'b1);

    // ---------------- random traffic, both widths ----------------
    sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(pick32(), pick32(), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (in_valid && rdy32) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_sent", sent, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_drained32", q32.size(), 0);
    chk("rand_drained8", q8.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
